priority_arbiter: RTL and testbench
===================================

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, max grant length in cycles before forced revoke; 0 disables timeout.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: enable  input  1  arbitration enable.
REQ-005 SHALL have port: req  input  8  per-channel request, bit i = channel i.
REQ-006 SHALL have port: release  input  1  current owner done, single-cycle pulse.
REQ-007 SHALL have port: grant_valid  output  1  a channel currently owns the resource.
REQ-008 SHALL have port: grant_id  output  3  index of owning channel.
REQ-009 SHALL have port: grant_onehot  output  8  one-hot of grant_id, all zero when grant_valid=0.
REQ-010 SHALL have port: timeout  output  1  one-cycle pulse when a grant is force-revoked.

Function
REQ-011 SHALL implement two states: IDLE, GRANT; all outputs registered.
REQ-012 IDLE: if enable=1 and req!=0 at edge, SHALL enter GRANT with grant_valid=1, grant_id=winner visible the following cycle (latency 1).
REQ-013 IDLE with enable=0 or req=0 SHALL stay IDLE, grant_valid=0.
REQ-014 Fixed-priority winner SHALL be the highest-index set bit of req (bit 7 highest).
REQ-015 In GRANT, grant_id and grant_onehot SHALL stay constant regardless of req changes, including owner dropping its req.
REQ-016 GRANT with release=1 SHALL return to IDLE; grant_valid=0 next cycle; no new grant in that same cycle (minimum one idle cycle between grants).
REQ-017 GRANT with enable=0 SHALL return to IDLE next cycle, no timeout pulse.
REQ-018 Cycle counter SHALL clear on GRANT entry and increment each GRANT cycle; when TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 without release, SHALL return to IDLE and pulse timeout=1 for exactly one cycle, coincident with grant_valid falling.
REQ-019 release and timeout condition in same cycle: release wins, timeout stays 0.
REQ-020 release while IDLE SHALL be ignored.
REQ-021 grant_id SHALL hold last value while grant_valid=0; grant_onehot SHALL be 0.

Reset
REQ-022 reset=1 at edge SHALL force IDLE, grant_valid=0, grant_id=0, grant_onehot=0, timeout=0, counter=0, round-robin pointer=0; reset overrides all inputs.
REQ-023 reset during GRANT SHALL revoke the grant next cycle with no timeout pulse.

Configuration
REQ-024 Macro ROUND_ROBIN_EN SHALL select arbitration policy.
REQ-025 Without ROUND_ROBIN_EN: fixed priority per REQ-014; no pointer register.
REQ-026 With ROUND_ROBIN_EN: 3-bit pointer holds last granted id (reset 0); search SHALL start at (pointer-1) mod 8 and descend with wrap 0->7, first set bit wins; pointer updates on each GRANT entry.
REQ-027 With ROUND_ROBIN_EN and pointer=0, ordering SHALL equal fixed priority (first grant after reset identical in both builds).

Verification
REQ-028 Reset, then enable=1, req=8'b11111010 -> next cycle grant_valid=1, grant_id=7, grant_onehot=8'b10000000.
REQ-029 During grant change req to 8'b00011100 -> grant_id remains 7 until release; release pulse -> grant_valid=0 next cycle, then grant_id=4 one cycle later.
REQ-030 Grant held with no release, TIMEOUT_CYCLES=16 -> grant_valid falls and timeout=1 for one cycle exactly 16 cycles after grant_valid rose.
REQ-031 enable=0, req=8'b10111010 -> grant_valid stays 0; req=0 with enable=1 -> grant_valid stays 0.
REQ-032 ROUND_ROBIN_EN, req held 8'b10000010, release every grant -> grant_id alternates 7,1,7,1; without macro -> 7,7,7,7.
REQ-033 reset asserted mid-grant with release=1 same cycle -> grant_valid=0, timeout=0, grant_id=0 next cycle.

Source files
------------

// File: rtl/priority_arbiter.sv
// Single-resource arbiter for 8 requesters with registered grant outputs and an
// optional per-grant timeout (TIMEOUT_CYCLES, 0 disables it).
// Policy: fixed priority (highest index wins) by default; define ROUND_ROBIN_EN
// to rotate priority downward from the last granted channel.
module priority_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       release_i,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic [7:0] grant_onehot,
  output logic       timeout
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic            grant_valid_q, grant_valid_d;
  logic [2:0]      grant_id_q, grant_id_d;
  logic [7:0]      grant_onehot_q, grant_onehot_d;
  logic            timeout_q, timeout_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      winner;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_q, ptr_d;

  // Search downward starting just below the last owner, wrapping 0 -> 7.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_q - 3'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Pointer remembers the channel granted on the most recent grant entry.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && enable && req != '0) begin
      ptr_d = winner;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the highest set request bit wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        winner = 3'(i);
      end
    end
  end
`endif

  // Next-state and next-output logic; grant_id is held while idle.
  always_comb begin
    state_d        = state_q;
    grant_valid_d  = grant_valid_q;
    grant_id_d     = grant_id_q;
    grant_onehot_d = grant_onehot_q;
    timeout_d      = 1'b0;
    cnt_d          = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (enable && req != '0) begin
          state_d        = StGrant;
          grant_valid_d  = 1'b1;
          grant_id_d     = winner;
          grant_onehot_d = 8'b1 << winner;
          cnt_d          = '0;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + CntW'(1);
        // Disable and release both end the grant quietly; release beats timeout.
        if (!enable || release_i) begin
          state_d        = StIdle;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
        end else if (TimeoutEn && cnt_q == CntMax) begin
          state_d        = StIdle;
          grant_valid_d  = 1'b0;
          grant_onehot_d = '0;
          timeout_d      = 1'b1;
        end
      end
      default: begin
        state_d        = StIdle;
        grant_valid_d  = 1'b0;
        grant_onehot_d = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      grant_valid_q  <= 1'b0;
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
      timeout_q      <= 1'b0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      grant_valid_q  <= grant_valid_d;
      grant_id_q     <= grant_id_d;
      grant_onehot_q <= grant_onehot_d;
      timeout_q      <= timeout_d;
      cnt_q          <= cnt_d;
    end
  end

  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign grant_onehot = grant_onehot_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: directed vector table, hand-written timeout and
// rotation sequences, then random traffic against a cycle-level reference model.
module tb_priority_arbiter;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       reset, enable, rel;
  logic [7:0] req;
  logic       grant_valid, timeout;
  logic [2:0] grant_id;
  logic [7:0] grant_onehot;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit       m_valid;
  bit [2:0] m_id;
  bit [2:0] m_ptr;
  bit       m_to;
  int       m_held;

  priority_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .req          (req),
    .release_i    (rel),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       rl;
    logic [7:0] rq;
    logic       ev;
    logic [2:0] eid;
    logic       eto;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Drive inputs away from the edge, let one edge pass, sample 1ns later.
  task automatic apply(input logic r, input logic e, input logic l, input logic [7:0] q);
    @(negedge clk);
    reset  = r;
    enable = e;
    rel    = l;
    req    = q;
    @(posedge clk);
    #1;
  endtask

  function automatic bit [7:0] onehot_of(input bit v, input bit [2:0] id);
    return v ? (8'd1 << id) : 8'd0;
  endfunction

  // First requester found walking down from (ptr-1) mod 8; ptr stays 0 in fixed mode.
  function automatic bit [2:0] pick(input logic [7:0] r, input bit [2:0] p);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (int'(p) - k + 16) % 8;
      if (r[idx]) return 3'(idx);
    end
    return 3'd0;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic l, input logic [7:0] q);
    m_to = 1'b0;
    if (r) begin
      m_valid = 1'b0;
      m_id    = '0;
      m_ptr   = '0;
      m_held  = 0;
    end else if (!m_valid) begin
      if (e && q != 8'd0) begin
        m_valid = 1'b1;
        m_id    = pick(q, m_ptr);
`ifdef ROUND_ROBIN_EN
        m_ptr   = m_id;
`endif
        m_held  = 0;
      end
    end else begin
      m_held++;
      if (!e || l) begin
        m_valid = 1'b0;
      end else if (T != 0 && m_held == int'(T)) begin
        m_valid = 1'b0;
        m_to    = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    bit [2:0] rr_exp[4];

    reset = 1'b1; enable = 1'b0; rel = 1'b0; req = '0;

    //           rst   en    rel   req     valid id    timeout
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'hFA, 1'b1, 3'd7, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 3'd7, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 3'd7, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 3'd7, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h1C, 1'b1, 3'd4, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 3'd4, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'hBA, 1'b0, 3'd4, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'hBA, 1'b0, 3'd4, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd4, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 3'd4, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 3'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 3'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 3'd0, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      string s;
      apply(tbl[i].rst, tbl[i].en, tbl[i].rl, tbl[i].rq);
      s = $sformatf("vec%0d", i);
      chk({s, ".valid"}, 8'(grant_valid), 8'(tbl[i].ev));
      chk({s, ".id"}, 8'(grant_id), 8'(tbl[i].eid));
      chk({s, ".onehot"}, grant_onehot, onehot_of(tbl[i].ev, tbl[i].eid));
      chk({s, ".timeout"}, 8'(timeout), 8'(tbl[i].eto));
    end

    // Held grant is force-revoked exactly T cycles after it became visible.
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 8'h01);
    chk("to.rise", 8'(grant_valid), 8'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      apply(1'b0, 1'b1, 1'b0, 8'h01);
      n++;
      if (!grant_valid) break;
    end
    chk("to.len", 8'(n), 8'(T));
    chk("to.pulse", 8'(timeout), 8'd1);
    chk("to.onehot", grant_onehot, 8'd0);
    apply(1'b0, 1'b1, 1'b0, 8'h01);
    chk("to.one_cycle", 8'(timeout), 8'd0);
    chk("to.regrant", 8'(grant_valid), 8'd1);

    // Release on the timeout cycle wins and suppresses the pulse.
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    apply(1'b0, 1'b1, 1'b0, 8'h08);
    for (int i = 0; i < int'(T) - 1; i++) apply(1'b0, 1'b1, 1'b0, 8'h08);
    chk("rel_to.held", 8'(grant_valid), 8'd1);
    apply(1'b0, 1'b1, 1'b1, 8'h08);
    chk("rel_to.valid", 8'(grant_valid), 8'd0);
    chk("rel_to.timeout", 8'(timeout), 8'd0);

    // Two requesters, release after every grant.
`ifdef ROUND_ROBIN_EN
    rr_exp = '{3'd7, 3'd1, 3'd7, 3'd1};
`else
    rr_exp = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 1'b0, 8'h82);
      chk($sformatf("rr%0d.valid", i), 8'(grant_valid), 8'd1);
      chk($sformatf("rr%0d.id", i), 8'(grant_id), 8'(rr_exp[i]));
      apply(1'b0, 1'b1, 1'b1, 8'h82);
    end

    // Random traffic against the reference model.
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    model_step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      logic       r, e, l;
      logic [7:0] q;
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 7) != 0);
      l = ($urandom_range(0, 5) == 0);
      q = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      apply(r, e, l, q);
      model_step(r, e, l, q);
      total++;
      if (grant_valid !== m_valid || grant_id !== m_id || timeout !== m_to ||
          grant_onehot !== onehot_of(m_valid, m_id)) begin
        bad++;
        $display("FAIL rand%0d: got v=%0b id=%0d oh=%02h to=%0b, expected v=%0b id=%0d oh=%02h to=%0b",
                 i, grant_valid, grant_id, grant_onehot, timeout,
                 m_valid, m_id, onehot_of(m_valid, m_id), m_to);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
